sss_demapper: RTL and testbench

- Sits directly downstream of the FFT demodulator.
- Consumes the per-symbol frequency-domain bin stream and the SSS-symbol qualifier.
- Extracts the 127 SSS subcarriers of the SSB and BPSK hard-decides each one from the sign of its real part.
- Presents the 127-bit SSS vector to the N_id_1 search stage over a valid/ready handshake, so SSS processing can run at the slower downstream rate.

---
 rtl/sss_demapper_pkg.sv | 17 +
 rtl/sss_demapper_if.sv | 34 +++
 rtl/sss_demapper.sv | 154 +++++++++++++++
 tb/tb_sss_demapper.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sss_demapper_pkg.sv
// Shared definitions for the SSS demapper slice.
// Contents: SSS vector length, the 127-bit hard-decision vector type and the
// demapper FSM state encoding.
package sss_pkg;

  localparam int SSS_LEN = 127;

  typedef logic [SSS_LEN-1:0] sss_bits_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    COLLECT = 2'd2,
    DRAIN   = 2'd3
  } sss_demap_state_t;

endpackage

// File: rtl/sss_demapper_if.sv
// Bus bundle for the SSS demapper.
// Input side : s_axis_in_tdata/tvalid/tlast (FFT bin stream, no backpressure)
//              and SSS_valid_i (SSS-symbol qualifier).
// Output side: m_axis_out_tdata/tvalid/tready (127-bit vector handshake) and
//              the dropped_o / aborted_o status pulses.
// slave  = demapper view, master = upstream/downstream (bench) view.
interface sss_demapper_if #(
  parameter int IN_DW = 32
);
  import sss_pkg::*;

  logic [IN_DW-1:0] s_axis_in_tdata;
  logic             s_axis_in_tvalid;
  logic             s_axis_in_tlast;
  logic             SSS_valid_i;
  sss_bits_t        m_axis_out_tdata;
  logic             m_axis_out_tvalid;
  logic             m_axis_out_tready;
  logic             dropped_o;
  logic             aborted_o;

  modport slave (
    input  s_axis_in_tdata, s_axis_in_tvalid, s_axis_in_tlast, SSS_valid_i,
    input  m_axis_out_tready,
    output m_axis_out_tdata, m_axis_out_tvalid, dropped_o, aborted_o
  );

  modport master (
    output s_axis_in_tdata, s_axis_in_tvalid, s_axis_in_tlast, SSS_valid_i,
    output m_axis_out_tready,
    input  m_axis_out_tdata, m_axis_out_tvalid, dropped_o, aborted_o
  );

endinterface

// File: rtl/sss_demapper.sv
// SSS demapper: picks the 127 SSS bins out of an fft-shifted symbol, BPSK
// hard-decides each from the sign of its real part and offers the resulting
// vector downstream over a valid/ready handshake.
// Ports: clk_i, reset_ni (async active-low), bus (sss_demapper_if.slave).
// A completed vector that finds the output still occupied is discarded
// (dropped_o); a symbol that ends or loses its qualifier early raises aborted_o.
module sss_demapper
  import sss_pkg::*;
#(
  parameter int IN_DW    = 32,
  parameter int NFFT     = 8,
  parameter int SC_START = 2**(NFFT-1) - 64
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  sss_demapper_if.slave  bus
);

  localparam int FFT_LEN = 2**NFFT;
  // One extra bit so the bin index can never wrap inside a symbol.
  localparam int CNT_W = $clog2(FFT_LEN) + 1;
  localparam logic [CNT_W-1:0] START_C = CNT_W'(SC_START);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(SC_START + SSS_LEN - 1);

  sss_demap_state_t state_r;
  logic [CNT_W-1:0] cnt_r;
  sss_bits_t        sr_r;
  sss_bits_t        tdata_r;
  logic             tvalid_r;
  logic             dropped_r;
  logic             aborted_r;

  logic             beat_s;
  logic             active_s;
  logic             hit_s;
  logic             collect_s;
  logic             complete_s;
  logic             abort_s;
  logic             hard_bit_s;
  sss_bits_t        sr_next_s;

  assign beat_s     = bus.s_axis_in_tvalid;
  // Negative real part decides a 1; only the sign bit matters.
  assign hard_bit_s = bus.s_axis_in_tdata[IN_DW/2-1];
  assign sr_next_s  = {hard_bit_s, sr_r[SSS_LEN-1:1]};
  assign complete_s = collect_s && (cnt_r == LAST_C);

  // Decode the current beat into collect / abort events.
  always_comb begin
    active_s  = 1'b0;
    hit_s     = 1'b0;
    collect_s = 1'b0;
    abort_s   = 1'b0;
    case (state_r)
      IDLE:          active_s = beat_s && bus.SSS_valid_i;
      SKIP, COLLECT: active_s = beat_s;
      DRAIN:         active_s = 1'b0;
      default:       active_s = 1'b0;
    endcase
    if (active_s) begin
      if (!bus.SSS_valid_i) begin
        abort_s = 1'b1;
      end else begin
        hit_s = (state_r == COLLECT) || (cnt_r == START_C);
        // tlast is only legal on the completion beat; in IDLE the symbol
        // never started, so there is nothing to report.
        if (bus.s_axis_in_tlast && !(hit_s && (cnt_r == LAST_C))) begin
          abort_s = (state_r != IDLE);
        end else begin
          collect_s = hit_s;
        end
      end
    end else begin
      abort_s = 1'b0;
    end
  end

  // FSM, bin counter, shift register and output vector register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      sr_r      <= {SSS_LEN{1'b0}};
      tdata_r   <= {SSS_LEN{1'b0}};
      tvalid_r  <= 1'b0;
      dropped_r <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      dropped_r <= 1'b0;
      aborted_r <= 1'b0;

      if (collect_s) begin
        sr_r <= sr_next_s;
      end

      if (abort_s) begin
        state_r   <= IDLE;
        cnt_r     <= {CNT_W{1'b0}};
        aborted_r <= 1'b1;
      end else if (beat_s) begin
        case (state_r)
          IDLE: begin
            if (bus.SSS_valid_i && !bus.s_axis_in_tlast) begin
              cnt_r   <= CNT_W'(1);
              state_r <= collect_s ? COLLECT : SKIP;
            end
          end
          SKIP: begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (collect_s) begin
              state_r <= COLLECT;
            end
          end
          COLLECT: begin
            if (complete_s) begin
              cnt_r   <= {CNT_W{1'b0}};
              // Remaining bins of this symbol must not restart the search.
              state_r <= bus.s_axis_in_tlast ? IDLE : DRAIN;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          DRAIN: begin
            if (bus.s_axis_in_tlast) begin
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end
        endcase
      end

      // A load in the same cycle as an accept keeps tvalid high.
      if (complete_s) begin
        if (!tvalid_r || bus.m_axis_out_tready) begin
          tdata_r  <= sr_next_s;
          tvalid_r <= 1'b1;
        end else begin
          dropped_r <= 1'b1;
        end
      end else if (tvalid_r && bus.m_axis_out_tready) begin
        tvalid_r <= 1'b0;
      end
    end
  end

  assign bus.m_axis_out_tdata  = tdata_r;
  assign bus.m_axis_out_tvalid = tvalid_r;
  assign bus.dropped_o         = dropped_r;
  assign bus.aborted_o         = aborted_r;

endmodule

// File: tb/tb_sss_demapper.sv
// Scoreboard bench for sss_demapper (NFFT=8, SC_START=64).
// The driver pushes expected vectors / tvalid-rise cycles into queues; a
// negedge monitor pops and compares on every handshake and tvalid rise.
module tb_sss_demapper;
  import sss_pkg::*;

  localparam int IN_DW    = 32;
  localparam int NFFT     = 8;
  localparam int FFT_LEN  = 256;
  localparam int SC_START = 64;
  localparam int LAST_BIN = SC_START + 126;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_drop = 0;
  int   n_abort = 0;
  int   n_xfer = 0;
  logic prev_tvalid = 1'b0;

  sss_bits_t exp_q[$];
  int        rise_q[$];
  sss_bits_t vec_a;
  sss_bits_t vec_b;

  sss_demapper_if #(.IN_DW(IN_DW)) bus ();

  sss_demapper #(.IN_DW(IN_DW), .NFFT(NFFT), .SC_START(SC_START)) dut (
    .clk_i   (clk),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: status pulse counting, tvalid rise timing, handshake scoreboard.
  initial forever begin
    @(negedge clk);
    if (bus.dropped_o) n_drop++;
    if (bus.aborted_o) n_abort++;
    if (bus.m_axis_out_tvalid && !prev_tvalid) begin
      if (rise_q.size() == 0) check("unexpected_rise", 128'd1, 128'd0);
      else check("rise_cycle", cyc, rise_q.pop_front());
    end
    if (bus.m_axis_out_tvalid && bus.m_axis_out_tready) begin
      n_xfer++;
      if (exp_q.size() == 0) check("unexpected_xfer", 128'd1, 128'd0);
      else check("tdata", bus.m_axis_out_tdata, exp_q.pop_front());
    end
    prev_tvalid = bus.m_axis_out_tvalid;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk_bin(input int b, input sss_bits_t bits);
    logic [15:0] re;
    re = 16'($urandom_range(0, 1000));
    if (b >= SC_START && b <= LAST_BIN) begin
      if (bits[b-SC_START]) re = 16'd0 - (re + 16'd1);
    end else begin
      re = 16'($urandom);
    end
    return {16'($urandom), re};
  endfunction

  task automatic drive_idle();
    @(posedge clk);
    #1;
    bus.s_axis_in_tvalid = 1'b0;
    bus.s_axis_in_tlast  = 1'b0;
    bus.SSS_valid_i      = 1'($urandom);
    bus.s_axis_in_tdata  = $urandom;
  endtask

  // One full symbol of FFT_LEN beats. drop_at: first beat with SSS_valid_i=0
  // (-1 = never). reset_at: beat after which reset is asserted (-1 = never).
  task automatic send_sym(input sss_bits_t bits, input bit gapped, input int drop_at,
                          input bit exp_out, input bit exp_rise, input bit ready_on_done,
                          input int reset_at);
    for (int b = 0; b < FFT_LEN; b++) begin
      if (gapped) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) drive_idle();
      end
      @(posedge clk);
      #1;
      bus.s_axis_in_tvalid = 1'b1;
      bus.s_axis_in_tdata  = mk_bin(b, bits);
      bus.s_axis_in_tlast  = (b == FFT_LEN - 1);
      bus.SSS_valid_i      = (drop_at < 0) || (b < drop_at);
      if (b == LAST_BIN && exp_out) begin
        exp_q.push_back(bits);
        if (exp_rise) rise_q.push_back(cyc + 1);
      end
      if (ready_on_done) begin
        if (b == LAST_BIN) bus.m_axis_out_tready = 1'b1;
        else if (b == LAST_BIN + 1) bus.m_axis_out_tready = 1'b0;
      end
      if (b == reset_at) begin
        #1 reset_ni = 1'b0;
        #1;
        check("rst_mid_tvalid", bus.m_axis_out_tvalid, 128'd0);
        check("rst_mid_tdata", bus.m_axis_out_tdata, 128'd0);
        check("rst_mid_dropped", bus.dropped_o, 128'd0);
        check("rst_mid_aborted", bus.aborted_o, 128'd0);
        exp_q.delete();
        rise_q.delete();
        bus.s_axis_in_tvalid = 1'b0;
        bus.s_axis_in_tlast  = 1'b0;
        bus.SSS_valid_i      = 1'b0;
        return;
      end
    end
    drive_idle();
  endtask

  initial begin
    logic [133:0] x;
    int d0;
    int a0;
    int x0;

    bus.s_axis_in_tvalid  = 1'b0;
    bus.s_axis_in_tdata   = 32'd0;
    bus.s_axis_in_tlast   = 1'b0;
    bus.SSS_valid_i       = 1'b0;
    bus.m_axis_out_tready = 1'b0;

    // SSS m-sequence x(i+7) = x(i+4) xor x(i), x(6:0) = 0000001; d(n) < 0 <=> x(n) = 1.
    x = '0;
    x[0] = 1'b1;
    for (int i = 0; i < 127; i++) x[i+7] = x[i+4] ^ x[i];
    for (int n = 0; n < 127; n++) vec_a[n] = x[n];
    for (int n = 0; n < 127; n++) vec_b[n] = x[(n + 43) % 127];

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", bus.m_axis_out_tvalid, 128'd0);
    check("rst_tdata", bus.m_axis_out_tdata, 128'd0);
    @(posedge clk);
    #1 reset_ni = 1'b1;
    @(negedge clk);
    check("rst_dropped", bus.dropped_o, 128'd0);
    check("rst_aborted", bus.aborted_o, 128'd0);

    // Basic extraction.
    bus.m_axis_out_tready = 1'b1;
    send_sym(vec_a, 1'b0, -1, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) drive_idle();
    check("basic_dropped", n_drop, 128'd0);
    check("basic_aborted", n_abort, 128'd0);

    // Gapped input.
    send_sym(vec_a, 1'b1, -1, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) drive_idle();

    // Abort at beat 100, then a clean symbol.
    a0 = n_abort;
    send_sym(vec_a, 1'b0, 100, 1'b0, 1'b0, 1'b0, -1);
    repeat (4) drive_idle();
    check("abort_count", n_abort, a0 + 1);
    check("abort_tvalid", bus.m_axis_out_tvalid, 128'd0);
    send_sym(vec_b, 1'b0, -1, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) drive_idle();

    // Backpressure: second completion is dropped, first vector held.
    bus.m_axis_out_tready = 1'b0;
    d0 = n_drop;
    send_sym(vec_a, 1'b0, -1, 1'b1, 1'b1, 1'b0, -1);
    send_sym(vec_b, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);
    repeat (3) drive_idle();
    check("bp_drop_count", n_drop, d0 + 1);
    @(negedge clk);
    check("bp_tvalid_held", bus.m_axis_out_tvalid, 128'd1);
    check("bp_tdata_held", bus.m_axis_out_tdata, vec_a);
    x0 = n_xfer;
    drive_idle();
    bus.m_axis_out_tready = 1'b1;
    repeat (4) drive_idle();
    check("bp_one_xfer", n_xfer, x0 + 1);
    check("bp_tvalid_clr", bus.m_axis_out_tvalid, 128'd0);

    // Simultaneous accept and load.
    bus.m_axis_out_tready = 1'b0;
    d0 = n_drop;
    send_sym(vec_a, 1'b0, -1, 1'b1, 1'b1, 1'b0, -1);
    send_sym(vec_b, 1'b0, -1, 1'b1, 1'b0, 1'b1, -1);
    repeat (2) drive_idle();
    check("sim_no_drop", n_drop, d0);
    @(negedge clk);
    check("sim_tvalid", bus.m_axis_out_tvalid, 128'd1);
    check("sim_tdata", bus.m_axis_out_tdata, vec_b);
    drive_idle();
    bus.m_axis_out_tready = 1'b1;
    repeat (3) drive_idle();

    // Async reset mid-COLLECT with a held vector present.
    bus.m_axis_out_tready = 1'b0;
    send_sym(vec_a, 1'b0, -1, 1'b1, 1'b1, 1'b0, -1);
    a0 = n_abort;
    send_sym(vec_b, 1'b0, -1, 1'b0, 1'b0, 1'b0, 120);
    repeat (3) drive_idle();
    @(posedge clk);
    #1 reset_ni = 1'b1;
    bus.m_axis_out_tready = 1'b1;
    send_sym(vec_b, 1'b0, -1, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) drive_idle();
    check("rst_no_abort", n_abort, a0);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) drive_idle();
    check("queue_drained", exp_q.size(), 128'd0);
    check("rise_drained", rise_q.size(), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
